spi_cmd_dispatch: RTL and testbench

Command decoder between the Jetson SPI receive path and the core. It pops 32-bit command words from the SPI→core FIFO, decodes the opcode nibble, and does one of three things:
- runs single register writes or reads on the core register bus,
- streams multi-word block payloads to a downstream consumer,
- posts read responses and error words into the core→SPI FIFO.

It is the only consumer of the SPI receive FIFO and shares the transmit FIFO write port with core status logic through an upstream arbiter.

---
 rtl/spi_cmd_dispatch_pkg.sv | 38 +++
 rtl/spi_cmd_dispatch_if.sv | 40 ++++
 rtl/spi_cmd_watchdog.sv | 45 ++++
 rtl/spi_cmd_dispatch.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_cmd_dispatch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_dispatch_pkg.sv
// Shared definitions for the SPI command dispatcher and the transmit-side
// response decoder: opcodes, error codes, response nibbles, FSM states and
// response word builders.
package spi_cmd_pkg;

    localparam logic [3:0] OP_WR  = 4'h1;
    localparam logic [3:0] OP_RD  = 4'h2;
    localparam logic [3:0] OP_BLK = 4'h3;

    localparam logic [3:0] ERR_BAD_OP  = 4'h1;
    localparam logic [3:0] ERR_BAD_LEN = 4'h2;
    localparam logic [3:0] ERR_TIMEOUT = 4'h3;

    localparam logic [3:0] RESP_NIB_RD  = 4'h2;
    localparam logic [3:0] RESP_NIB_ERR = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_REG    = 3'd2,
        ST_BLK    = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Error response: {F, 0, opcode, code, addr, 0}
    function automatic logic [31:0] err_word(input logic [3:0]  op,
                                             input logic [3:0]  code,
                                             input logic [11:0] addr);
        return {RESP_NIB_ERR, 4'h0, op, code, addr, 4'h0};
    endfunction

    // Read response: {2, addr, data}
    function automatic logic [31:0] rd_word(input logic [11:0] addr,
                                            input logic [15:0] data);
        return {RESP_NIB_RD, addr, data};
    endfunction

endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// Bundle of the receive FIFO, transmit FIFO, register bus and payload
// stream signals around the command dispatcher. The master modport is the
// dispatcher side; slave is the surrounding system.
interface spi_cmd_dispatch_if;

    logic        cmd_rdy;
    logic [31:0] cmd_dout;
    logic        cmd_rd_en;

    logic        resp_full;
    logic        resp_wr_en;
    logic [31:0] resp_din;

    logic        reg_wr;
    logic        reg_rd;
    logic [11:0] reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        reg_ack;

    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_data;
    logic        blk_last;

    logic [7:0]  err_cnt;

    modport master (
        input  cmd_rdy, cmd_dout, resp_full, reg_rdata, reg_ack, blk_ready,
        output cmd_rd_en, resp_wr_en, resp_din, reg_wr, reg_rd, reg_addr,
               reg_wdata, blk_valid, blk_data, blk_last, err_cnt
    );

    modport slave (
        output cmd_rdy, cmd_dout, resp_full, reg_rdata, reg_ack, blk_ready,
        input  cmd_rd_en, resp_wr_en, resp_din, reg_wr, reg_rd, reg_addr,
               reg_wdata, blk_valid, blk_data, blk_last, err_cnt
    );

endinterface

// File: rtl/spi_cmd_watchdog.sv
// Stall watchdog for the command dispatcher. Only built when
// SPI_CMD_TIMEOUT_EN is defined. Counts while run_i is high, restarts on
// clear_i, and flags expiry once the count reaches LIMIT.
`ifdef SPI_CMD_TIMEOUT_EN
module spi_cmd_watchdog #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = ($clog2(LIMIT + 1) < 10) ? 10 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then count up and hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CW{1'b0}};
        end else if (run_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i & ~clear_i & (cnt_q == LIMIT_C);

endmodule
`endif

// File: rtl/spi_cmd_dispatch.sv
// SPI command dispatcher: pops header words from the receive FIFO, runs
// register writes/reads, streams block payloads, and posts read responses
// and error words to the transmit FIFO.
// Optional feature: define SPI_CMD_TIMEOUT_EN to enable the reg_ack and
// payload starvation watchdog (error code 3).
module spi_cmd_dispatch
    import spi_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned MAX_BLK_LEN    = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_cmd_dispatch_if.master   bus
);

    localparam logic [31:0] MAX_LEN_C = 32'(MAX_BLK_LEN);

    state_e      state_q, state_d;
    logic [31:0] hdr_q, hdr_d;
    logic [11:0] remaining_q, remaining_d;
    logic        reg_wr_q, reg_wr_d;
    logic        reg_rd_q, reg_rd_d;
    logic [31:0] resp_din_q, resp_din_d;
    logic        resp_err_q, resp_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        active_q;

    logic        cmd_rd_en_s;
    logic        resp_wr_en_s;
    logic        blk_valid_s;
    logic        blk_last_s;
    logic [31:0] blk_data_s;
    logic        xfer_s;
    logic        timeout_s;

    logic [3:0]  op_s;
    logic [11:0] addr_s;
    logic [15:0] len_s;

    assign op_s   = hdr_q[31:28];
    assign addr_s = hdr_q[27:16];
    assign len_s  = hdr_q[15:0];

    assign xfer_s = (state_q == ST_BLK) & bus.cmd_rdy & bus.blk_ready;

`ifdef SPI_CMD_TIMEOUT_EN
    logic wd_run_s;
    logic wd_clear_s;

    // Count in REG, and in BLK only while no word moves; restart elsewhere
    assign wd_run_s   = (state_q == ST_REG) | ((state_q == ST_BLK) & ~xfer_s);
    assign wd_clear_s = ~((state_q == ST_REG) | (state_q == ST_BLK)) | xfer_s;

    spi_cmd_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (wd_run_s),
        .clear_i   (wd_clear_s),
        .expired_o (timeout_s)
    );
`else
    logic unused_tmo_s;

    assign timeout_s    = 1'b0;
    assign unused_tmo_s = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic and combinational FIFO/stream handshakes
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        remaining_d  = remaining_q;
        reg_wr_d     = reg_wr_q;
        reg_rd_d     = reg_rd_q;
        resp_din_d   = resp_din_q;
        resp_err_d   = resp_err_q;
        err_cnt_d    = err_cnt_q;
        cmd_rd_en_s  = 1'b0;
        resp_wr_en_s = 1'b0;
        blk_valid_s  = 1'b0;
        blk_last_s   = 1'b0;
        blk_data_s   = 32'd0;

        case (state_q)
            ST_IDLE: begin
                cmd_rd_en_s = bus.cmd_rdy & active_q;
                if (bus.cmd_rdy && active_q) begin
                    hdr_d   = bus.cmd_dout;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DECODE: begin
                case (op_s)
                    OP_WR: begin
                        reg_wr_d = 1'b1;
                        state_d  = ST_REG;
                    end
                    OP_RD: begin
                        reg_rd_d = 1'b1;
                        state_d  = ST_REG;
                    end
                    OP_BLK: begin
                        if ({16'd0, len_s} > MAX_LEN_C) begin
                            // Payload is left in the FIFO on purpose
                            resp_din_d = err_word(op_s, ERR_BAD_LEN, addr_s);
                            resp_err_d = 1'b1;
                            state_d    = ST_RESP;
                        end else if (len_s == 16'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            remaining_d = len_s[11:0];
                            state_d     = ST_BLK;
                        end
                    end
                    default: begin
                        resp_din_d = err_word(op_s, ERR_BAD_OP, addr_s);
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                endcase
            end

            ST_REG: begin
                if (bus.reg_ack) begin
                    reg_wr_d = 1'b0;
                    reg_rd_d = 1'b0;
                    if (reg_rd_q) begin
                        resp_din_d = rd_word(addr_s, bus.reg_rdata);
                        resp_err_d = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    reg_wr_d   = 1'b0;
                    reg_rd_d   = 1'b0;
                    resp_din_d = err_word(op_s, ERR_TIMEOUT, addr_s);
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_REG;
                end
            end

            ST_BLK: begin
                blk_valid_s = bus.cmd_rdy;
                blk_data_s  = bus.cmd_dout;
                blk_last_s  = (remaining_q == 12'd1);
                cmd_rd_en_s = bus.cmd_rdy & bus.blk_ready;
                if (xfer_s) begin
                    remaining_d = remaining_q - 12'd1;
                    if (remaining_q == 12'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BLK;
                    end
                end else if (timeout_s) begin
                    resp_din_d = err_word(op_s, ERR_TIMEOUT, 12'd0);
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_BLK;
                end
            end

            ST_RESP: begin
                if (!bus.resp_full) begin
                    resp_wr_en_s = 1'b1;
                    state_d      = ST_IDLE;
                    if (resp_err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Header, counters, strobes and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q       <= 32'd0;
            remaining_q <= 12'd0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            resp_din_q  <= 32'd0;
            resp_err_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
            active_q    <= 1'b0;
        end else begin
            hdr_q       <= hdr_d;
            remaining_q <= remaining_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            resp_din_q  <= resp_din_d;
            resp_err_q  <= resp_err_d;
            err_cnt_q   <= err_cnt_d;
            // Keeps the pop strobe low while reset is asserted
            active_q    <= 1'b1;
        end
    end

    assign bus.cmd_rd_en  = cmd_rd_en_s;
    assign bus.resp_wr_en = resp_wr_en_s;
    assign bus.resp_din   = resp_din_q;
    assign bus.reg_wr     = reg_wr_q;
    assign bus.reg_rd     = reg_rd_q;
    assign bus.reg_addr   = addr_s;
    assign bus.reg_wdata  = len_s;
    assign bus.blk_valid  = blk_valid_s;
    assign bus.blk_data   = blk_data_s;
    assign bus.blk_last   = blk_last_s;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Directed testbench for spi_cmd_dispatch: a table of single commands with
// hand-computed results, plus sequences for back-to-back writes, block
// streaming, transmit back-pressure, timeout and error-count saturation.
module tb_spi_cmd_dispatch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_dispatch_if bus ();

    spi_cmd_dispatch #(
        .TIMEOUT_CYCLES (15),
        .MAX_BLK_LEN    (4095)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hdr;
        logic [15:0] rdata;
        int          ack;
        int          exp_wr;
        int          exp_rd;
        logic [11:0] exp_addr;
        logic [15:0] exp_wdata;
        int          exp_resp;
        logic [31:0] exp_din;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [9];

    int total = 0;
    int bad   = 0;

    logic [31:0] fifo [$];
    int          tick_n;
    bit          ready_toggle;
    int          full_ticks;
    int          ack_dly;
    logic [15:0] rdata;
    int          strobe_cyc;

    int          wr_cyc, rd_cyc, both_cyc, resp_n, resp_full_wr, first_strobe;
    logic [11:0] seen_addr;
    logic [15:0] seen_wdata;
    logic [31:0] seen_resp;
    int          pop_ticks [$];
    logic [31:0] xfer_data [$];
    logic        xfer_last [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        tick_n = 0; wr_cyc = 0; rd_cyc = 0; both_cyc = 0; resp_n = 0;
        resp_full_wr = 0; first_strobe = -1; strobe_cyc = 0;
        seen_addr = 12'd0; seen_wdata = 16'd0; seen_resp = 32'd0;
        pop_ticks.delete(); xfer_data.delete(); xfer_last.delete();
    endtask

    // One clock: drive inputs at negedge, sample 1 ns later, model the FIFO pop
    task automatic tick();
        @(negedge clk);
        bus.cmd_rdy  = (fifo.size() > 0);
        bus.cmd_dout = (fifo.size() > 0) ? fifo[0] : 32'd0;
        if (bus.reg_wr || bus.reg_rd) strobe_cyc++;
        else strobe_cyc = 0;
        bus.reg_ack   = (ack_dly != 0) && (strobe_cyc == ack_dly);
        bus.reg_rdata = rdata;
        bus.blk_ready = ready_toggle ? tick_n[0] : 1'b1;
        bus.resp_full = (tick_n < full_ticks);
        #1;
        if (bus.reg_wr) begin
            wr_cyc++; seen_addr = bus.reg_addr; seen_wdata = bus.reg_wdata;
            if (first_strobe < 0) first_strobe = tick_n;
        end
        if (bus.reg_rd) begin
            rd_cyc++; seen_addr = bus.reg_addr;
            if (first_strobe < 0) first_strobe = tick_n;
        end
        if (bus.reg_wr && bus.reg_rd) both_cyc++;
        if (bus.resp_wr_en) begin
            resp_n++; seen_resp = bus.resp_din;
            if (bus.resp_full) resp_full_wr++;
        end
        if (bus.blk_valid && bus.blk_ready) begin
            xfer_data.push_back(bus.blk_data);
            xfer_last.push_back(bus.blk_last);
        end
        if (bus.cmd_rd_en && bus.cmd_rdy) begin
            pop_ticks.push_back(tick_n);
            void'(fifo.pop_front());
        end
        tick_n++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        //          hdr           rdata    ack wr rd addr     wdata     rsp din            err
        vecs[0] = '{32'h1012ABCD, 16'h0000, 3, 3, 0, 12'h012, 16'hABCD, 0, 32'h00000000, 8'd0};
        vecs[1] = '{32'h20340000, 16'h5A5A, 1, 0, 1, 12'h034, 16'h0000, 1, 32'h20345A5A, 8'd0};
        vecs[2] = '{32'h1FFF0000, 16'h0000, 1, 1, 0, 12'hFFF, 16'h0000, 0, 32'h00000000, 8'd0};
        vecs[3] = '{32'h2ABC1234, 16'hFFFF, 2, 0, 2, 12'hABC, 16'h0000, 1, 32'h2ABCFFFF, 8'd0};
        vecs[4] = '{32'h70000000, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 1, 32'hF0710000, 8'd1};
        vecs[5] = '{32'hF1230000, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 1, 32'hF0F11230, 8'd2};
        vecs[6] = '{32'h30011000, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 1, 32'hF0320010, 8'd3};
        vecs[7] = '{32'h30050000, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 0, 32'h00000000, 8'd3};
        vecs[8] = '{32'h4ABC0000, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 1, 32'hF041ABC0, 8'd4};

        ready_toggle = 1'b0; full_ticks = 0; ack_dly = 0; rdata = 16'd0;
        clear_rec();

        // Reset: pop gated even with a word offered
        bus.cmd_rdy = 1'b1; bus.cmd_dout = 32'h1012ABCD; bus.resp_full = 1'b0;
        bus.reg_rdata = 16'd0; bus.reg_ack = 1'b0; bus.blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_rd_en", {31'd0, bus.cmd_rd_en}, 32'd0);
        check("rst_reg_strobes", {30'd0, bus.reg_wr, bus.reg_rd}, 32'd0);
        check("rst_resp_wr_en", {31'd0, bus.resp_wr_en}, 32'd0);
        check("rst_resp_din", bus.resp_din, 32'd0);
        check("rst_blk", {30'd0, bus.blk_valid, bus.blk_last}, 32'd0);
        check("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        bus.cmd_rdy = 1'b0; bus.cmd_dout = 32'd0;
        rst_n = 1'b1;
        run(3);

        // Table of single commands
        for (int i = 0; i < 9; i++) begin
            clear_rec();
            fifo.push_back(vecs[i].hdr);
            rdata = vecs[i].rdata; ack_dly = vecs[i].ack;
            run(12);
            check($sformatf("v%0d_wr_cycles", i), 32'(wr_cyc), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_rd_cycles", i), 32'(rd_cyc), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_both_strobes", i), 32'(both_cyc), 32'd0);
            check($sformatf("v%0d_resp_count", i), 32'(resp_n), 32'(vecs[i].exp_resp));
            check($sformatf("v%0d_err_cnt", i), {24'd0, bus.err_cnt}, {24'd0, vecs[i].exp_err});
            if (vecs[i].exp_wr + vecs[i].exp_rd > 0) begin
                check($sformatf("v%0d_addr", i), {20'd0, seen_addr}, {20'd0, vecs[i].exp_addr});
                check($sformatf("v%0d_strobe_latency", i),
                      32'(first_strobe - ((pop_ticks.size() > 0) ? pop_ticks[0] : -100)), 32'd2);
            end
            if (vecs[i].exp_wr > 0)
                check($sformatf("v%0d_wdata", i), {16'd0, seen_wdata}, {16'd0, vecs[i].exp_wdata});
            if (vecs[i].exp_resp > 0)
                check($sformatf("v%0d_resp_din", i), seen_resp, vecs[i].exp_din);
        end

        // Back-to-back writes, ack in the first strobe cycle
        clear_rec();
        fifo.push_back(32'h10100001); fifo.push_back(32'h10200002);
        ack_dly = 1;
        run(12);
        check("b2b_pops", 32'(pop_ticks.size()), 32'd2);
        check("b2b_pop_gap", 32'((pop_ticks.size() == 2) ? pop_ticks[1] - pop_ticks[0] : -1), 32'd3);
        check("b2b_wr_cycles", 32'(wr_cyc), 32'd2);

        // Block of three with blk_ready toggling, followed by a WR header
        clear_rec();
        fifo.push_back(32'h30000003);
        fifo.push_back(32'hA0000001); fifo.push_back(32'hB0000002); fifo.push_back(32'hC0000003);
        fifo.push_back(32'h10550001);
        ready_toggle = 1'b1; ack_dly = 1;
        run(20);
        ready_toggle = 1'b0;
        check("blk_xfer_count", 32'(xfer_data.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_w;
            exp_w = 32'hA0000001 + (32'(k) * 32'h10000001);
            check($sformatf("blk_data%0d", k), (k < xfer_data.size()) ? xfer_data[k] : 32'hDEADDEAD, exp_w);
            check($sformatf("blk_last%0d", k), (k < xfer_last.size()) ? {31'd0, xfer_last[k]} : 32'hDEADDEAD,
                  (k == 2) ? 32'd1 : 32'd0);
        end
        check("blk_then_wr_addr", {20'd0, seen_addr}, 32'h055);
        check("blk_then_wr_cycles", 32'(wr_cyc), 32'd1);

        // RD response held back by resp_full for 11 cycles
        clear_rec();
        fifo.push_back(32'h20560000); fifo.push_back(32'h10770000);
        rdata = 16'h1357; ack_dly = 1; full_ticks = 14;
        run(24);
        full_ticks = 0;
        check("full_write_while_full", 32'(resp_full_wr), 32'd0);
        check("full_resp_count", 32'(resp_n), 32'd1);
        check("full_resp_din", seen_resp, 32'h20561357);
        check("full_next_pop_tick", 32'((pop_ticks.size() == 2) ? pop_ticks[1] : -1), 32'd15);

`ifdef SPI_CMD_TIMEOUT_EN
        // RD that never gets an ack
        clear_rec();
        fifo.push_back(32'h20340000);
        ack_dly = 0;
        run(40);
        check("tmo_rd_dropped", {31'd0, bus.reg_rd}, 32'd0);
        check("tmo_resp_count", 32'(resp_n), 32'd1);
        check("tmo_resp_din", seen_resp, 32'hF0230340);
        check("tmo_err_cnt", {24'd0, bus.err_cnt}, 32'd5);
        ack_dly = 1;
`endif

        // 256 more errors: counter saturates
        clear_rec();
        for (int k = 0; k < 256; k++) fifo.push_back(32'h80000000);
        for (int k = 0; k < 2000; k++) begin
            if (fifo.size() == 0) break;
            tick();
        end
        run(6);
        check("sat_fifo_drained", 32'(fifo.size()), 32'd0);
        check("sat_resp_count", 32'(resp_n), 32'd256);
        check("sat_err_cnt", {24'd0, bus.err_cnt}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
